afu_mac_array: RTL and testbench

AFU_MAC_ARRAY -- requirements
Module: afu_mac_array

---
 rtl/afu_mac_pkg.sv | 46 ++++
 rtl/afu_mac_array_lane.sv | 52 +++++
 rtl/afu_mac_array.sv | 99 +++++++++
 tb/tb_afu_mac_array.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/afu_mac_pkg.sv
// Shared types and helpers for the fixed-point MAC array: controller states,
// default fixed-point constants and the round-half-up / saturate function.
package afu_mac_pkg;

    localparam int FRAC_BITS_DEF = 8;
    localparam int ACC_WIDTH_DEF = 40;
    // Working width of sat_round; accumulators up to SAT_W-1 bits are supported.
    localparam int SAT_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HOLD  = 2'd3
    } mac_state_e;

    typedef struct packed {
        logic             sat;
        logic [SAT_W-1:0] value;
    } sat_res_t;

    function automatic sat_res_t sat_round(input logic signed [SAT_W-1:0] acc,
                                           input int frac, input int dw);
        logic signed [SAT_W-1:0] half;
        logic signed [SAT_W-1:0] shifted;
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        sat_res_t res;
        half    = (frac > 0) ? (SAT_W'(1) << (frac - 1)) : '0;
        shifted = (acc + half) >>> frac;
        max_v   = (SAT_W'(1) << (dw - 1)) - SAT_W'(1);
        min_v   = ~max_v;
        if (shifted > max_v) begin
            res.sat   = 1'b1;
            res.value = max_v;
        end else if (shifted < min_v) begin
            res.sat   = 1'b1;
            res.value = min_v;
        end else begin
            res.sat   = 1'b0;
            res.value = shifted;
        end
        return res;
    endfunction

endpackage

// File: rtl/afu_mac_array_lane.sv
// One MAC lane: registered signed product, wrapping accumulator and a
// registered rounded/saturated result.
module fxp_mac_lane
    import afu_mac_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = FRAC_BITS_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic                         beat_en,
    input  logic                         add_en,
    input  logic                         res_load,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic        [DATA_WIDTH-1:0] result,
    output logic                         sat
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    acc;
    sat_res_t                       rs;
    logic                           unused_hi;

    assign rs        = sat_round({{(SAT_W-ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc}, FRAC_BITS, DATA_WIDTH);
    assign unused_hi = ^rs.value[SAT_W-1:DATA_WIDTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod   <= '0;
            acc    <= '0;
            result <= '0;
            sat    <= 1'b0;
        end else begin
            if (clear) begin
                prod <= '0;
                acc  <= '0;
            end else begin
                if (beat_en) prod <= a * b;
                // Accumulator wraps; only the final result saturates.
                if (add_en) acc <= acc + {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
            end
            if (res_load) begin
                result <= rs.value[DATA_WIDTH-1:0];
                sat    <= rs.sat;
            end
        end
    end

endmodule

// File: rtl/afu_mac_array.sv
// Dot-product engine: LANES fixed-point MAC lanes fed one 512-bit line per beat,
// sequenced by an IDLE/ACC/FLUSH/HOLD controller with a valid/ready result port.
module afu_mac_array
    import afu_mac_pkg::*;
#(
    parameter int LANES      = 8,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = FRAC_BITS_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      ctx_length,
    input  logic             start,
    output logic             busy,
    input  logic [511:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [511:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LANES-1:0] sat_flags
);

    mac_state_e                state, state_nxt;
    logic [31:0]               length, count;
    logic                      prod_vld, flush_cnt;
    logic                      accept, last_beat, start_ok, res_load, clear;
    logic [DATA_WIDTH-1:0]     lane_res [LANES];

    assign accept    = in_valid && in_ready;
    assign last_beat = accept && ((count + 32'd1) == length);
    assign start_ok  = (state == ST_IDLE) && start && (ctx_length != 32'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            length    <= '0;
            count     <= '0;
            prod_vld  <= 1'b0;
            flush_cnt <= 1'b0;
        end else begin
            state    <= state_nxt;
            prod_vld <= accept;
            if (start_ok) begin
                length <= ctx_length;
                count  <= '0;
            end else if (accept) begin
                count <= count + 32'd1;
            end
            // Two FLUSH cycles: drain the product stage, then form results.
            if (state == ST_FLUSH) flush_cnt <= ~flush_cnt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_ok)  state_nxt = ST_ACC;
            ST_ACC:   if (last_beat) state_nxt = ST_FLUSH;
            ST_FLUSH: if (flush_cnt) state_nxt = ST_HOLD;
            ST_HOLD:  if (out_ready) state_nxt = ST_IDLE;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_ACC);
        out_valid = (state == ST_HOLD);
        busy      = (state != ST_IDLE);
        res_load  = (state == ST_FLUSH) && flush_cnt;
        clear     = start_ok;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fxp_mac_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .FRAC_BITS  (FRAC_BITS),
            .ACC_WIDTH  (ACC_WIDTH)
        ) u_lane (
            .clk      (clk),
            .reset_n  (reset_n),
            .clear    (clear),
            .beat_en  (accept),
            .add_en   (prod_vld),
            .res_load (res_load),
            .a        (in_data[2*DATA_WIDTH*i +: DATA_WIDTH]),
            .b        (in_data[2*DATA_WIDTH*i+DATA_WIDTH +: DATA_WIDTH]),
            .result   (lane_res[i]),
            .sat      (sat_flags[i])
        );
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < LANES; i++) out_data[DATA_WIDTH*i +: DATA_WIDTH] = lane_res[i];
    end

endmodule

// File: tb/tb_afu_mac_array.sv
// Scoreboard bench for afu_mac_array: directed jobs push hand-computed results,
// a negedge monitor pops and compares on every output handshake.
module tb_afu_mac_array;

    localparam int LANES = 8;
    localparam int DW    = 16;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [31:0]      ctx_length = '0;
    logic             start = 1'b0;
    logic             busy;
    logic [511:0]     in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [511:0]     out_data;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [LANES-1:0] sat_flags;

    typedef struct packed {
        logic [511:0]     data;
        logic [LANES-1:0] sat;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    afu_mac_array #(.LANES(LANES), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ctx_length (ctx_length),
        .start      (start),
        .busy       (busy),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sat_flags  (sat_flags)
    );

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got %h with nothing expected", out_data);
            end else begin
                mon_e = sb_q.pop_front();
                check("out_data", out_data, mon_e.data);
                check("sat_flags", 512'(sat_flags), 512'(mon_e.sat));
            end
        end
    end

    function automatic logic [511:0] line_all(input logic [15:0] a, input logic [15:0] b);
        logic [511:0] l;
        l = '0;
        for (int i = 0; i < LANES; i++) begin
            l[32*i +: 16]    = a;
            l[32*i+16 +: 16] = b;
        end
        return l;
    endfunction

    function automatic logic [511:0] res_all(input logic [15:0] r);
        logic [511:0] l;
        l = '0;
        for (int i = 0; i < LANES; i++) l[16*i +: 16] = r;
        return l;
    endfunction

    task automatic push_exp(input logic [511:0] d, input logic [LANES-1:0] s);
        exp_t e;
        e.data = d;
        e.sat  = s;
        sb_q.push_back(e);
    endtask

    task automatic do_start(input logic [31:0] len);
        @(posedge clk); #1;
        ctx_length = len;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic send_beat(input logic [511:0] d);
        int g;
        g        = 0;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_accept: in_ready got %0b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic bubble(input logic [511:0] junk);
        in_data  = junk;
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_latency(input int exp_lat);
        int lat;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 512'(lat), 512'(exp_lat));
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        @(negedge clk);
        while (busy && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("return_to_idle", 512'(busy), 512'(0));
    endtask

    initial begin
        logic [511:0] l;
        logic [511:0] e;

        // Reset state
        #12;
        check("rst_busy", 512'(busy), 512'(0));
        check("rst_in_ready", 512'(in_ready), 512'(0));
        check("rst_out_valid", 512'(out_valid), 512'(0));
        check("rst_out_data", out_data, 512'(0));
        check("rst_sat_flags", 512'(sat_flags), 512'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;

        // 1.0 * 2.0 on all lanes, one beat
        push_exp(res_all(16'h0200), 8'h00);
        do_start(32'd1);
        send_beat(line_all(16'h0100, 16'h0200));
        check_latency(3);
        wait_idle();

        // Four beats with bubbles carrying junk; lane3/lane4 exercise round-half-up
        l = '0;
        l[0*32 +: 16] = 16'h0180; l[0*32+16 +: 16] = 16'h0100;
        l[3*32 +: 16] = 16'h0001; l[3*32+16 +: 16] = 16'h0020;
        l[4*32 +: 16] = 16'hFFFF; l[4*32+16 +: 16] = 16'h0020;
        e = '0;
        e[0*16 +: 16] = 16'h0600;
        e[3*16 +: 16] = 16'h0001;
        e[4*16 +: 16] = 16'h0000;
        push_exp(e, 8'h00);
        do_start(32'd4);
        send_beat(l);
        bubble(line_all(16'h7FFF, 16'h7FFF));
        send_beat(l);
        bubble(line_all(16'h7FFF, 16'h7FFF));
        bubble(line_all(16'h7FFF, 16'h7FFF));
        send_beat(l);
        send_beat(l);
        check_latency(3);
        wait_idle();

        // Saturation both directions
        l = '0;
        l[1*32 +: 16] = 16'h7FFF; l[1*32+16 +: 16] = 16'h7FFF;
        l[2*32 +: 16] = 16'h7FFF; l[2*32+16 +: 16] = 16'h8000;
        e = '0;
        e[1*16 +: 16] = 16'h7FFF;
        e[2*16 +: 16] = 16'h8000;
        push_exp(e, 8'b0000_0110);
        do_start(32'd2);
        send_beat(l);
        send_beat(l);
        check_latency(3);
        wait_idle();

        // HOLD back-pressure: 3.0 * -1.0, out_ready low for 10 cycles
        out_ready = 1'b0;
        push_exp(res_all(16'hFD00), 8'h00);
        do_start(32'd1);
        send_beat(line_all(16'h0300, 16'hFF00));
        check_latency(3);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            start      = (k == 3);
            ctx_length = 32'd1;
            @(negedge clk);
            check("hold_out_data", out_data, res_all(16'hFD00));
            check("hold_in_ready", 512'(in_ready), 512'(0));
            check("hold_out_valid", 512'(out_valid), 512'(1));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        @(negedge clk);
        check("post_hs_busy", 512'(busy), 512'(0));
        check("post_hs_out_valid", 512'(out_valid), 512'(0));
        @(negedge clk);
        check("hs_start_ignored", 512'(busy), 512'(0));

        // Reset mid-accumulation, then a clean job
        do_start(32'd8);
        send_beat(line_all(16'h0100, 16'h0100));
        send_beat(line_all(16'h0100, 16'h0100));
        send_beat(line_all(16'h0100, 16'h0100));
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_busy", 512'(busy), 512'(0));
        check("abort_in_ready", 512'(in_ready), 512'(0));
        check("abort_out_valid", 512'(out_valid), 512'(0));
        check("abort_out_data", out_data, 512'(0));
        check("abort_sat_flags", 512'(sat_flags), 512'(0));
        @(negedge clk);
        reset_n = 1'b1;
        push_exp(res_all(16'h0100), 8'h00);
        do_start(32'd1);
        send_beat(line_all(16'h0100, 16'h0100));
        check_latency(3);
        wait_idle();

        // Zero-length start is ignored
        do_start(32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("zero_len_busy", 512'(busy), 512'(0));
            check("zero_len_in_ready", 512'(in_ready), 512'(0));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 512'(sb_q.size()), 512'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
